// File: rtl/breakout_pkg.sv
// Shared breakout constants and the ball state encoding.
package breakout_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   typedef enum logic [1:0] {
      StServe = 2'd0,
      StMove  = 2'd1,
      StLost  = 2'd2,
      StOver  = 2'd3
   } ball_state_t;

endpackage

// File: rtl/ball_motion.sv
// Ball motion for breakout: serve, frame-stepped movement, wall/paddle/brick
// bounces, ball loss and life counting.
// Optional feature macro: BALL_SPEEDUP_EN (step grows by 1 every 8th paddle
// bounce, saturating at STEP+2, reset to STEP when the ball is lost).
module ball_motion
   import breakout_pkg::*;
#(
   parameter int unsigned H_SIZE   = 3,
   parameter int unsigned START_X  = 320,
   parameter int unsigned START_Y  = 400,
   parameter int unsigned PADDLE_Y = 440,
   parameter int unsigned PADDLE_W = 64,
   parameter int unsigned STEP     = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       frame_tick,
   input  logic       launch,
   input  logic       brick_hit,
   input  logic [9:0] paddle_x,
   output logic [9:0] ball_x,
   output logic [8:0] ball_y,
   output logic [1:0] lives,
   output logic       ball_lost,
   output logic       game_over
);

   // All geometry is compared at 11 bits so nothing wraps near 0.
   localparam logic [10:0] HS     = 11'(H_SIZE);
   localparam logic [10:0] XMax   = 11'(SCREEN_W - 1);
   localparam logic [10:0] YMax   = 11'(SCREEN_H - 1);
   localparam logic [10:0] PadY   = 11'(PADDLE_Y);
   localparam logic [10:0] PadWm1 = 11'(PADDLE_W - 1);
   localparam logic [9:0]  StartX = 10'(START_X);
   localparam logic [8:0]  StartY = 9'(START_Y);

   ball_state_t r_state, w_state_nxt;
   logic [9:0]  r_x, w_x_nxt;
   logic [8:0]  r_y, w_y_nxt;
   logic        r_dir_right, w_dir_right_nxt;
   logic        r_dir_down, w_dir_down_nxt;
   logic [1:0]  r_lives, w_lives_nxt;
   logic        r_lost, w_lost_nxt;
   logic        r_pend, w_pend_nxt;
   logic [10:0] w_x, w_y, w_pad_l, w_step;
   logic        w_top, w_pad, w_bottom, w_wall;

`ifdef BALL_SPEEDUP_EN
   localparam logic [3:0] StepMax = 4'(STEP + 2);
   logic [3:0] r_step, w_step_nxt;
   logic [2:0] r_bounce, w_bounce_nxt;
   assign w_step = {7'd0, r_step};
`else
   assign w_step = 11'(STEP);
`endif

   assign w_x     = {1'b0, r_x};
   assign w_y     = {2'b0, r_y};
   assign w_pad_l = {1'b0, paddle_x};

   // Collision terms, evaluated against the current direction
   assign w_top    = !r_dir_down && (w_y <= HS + w_step);
   assign w_pad    = r_dir_down && (w_y + HS >= PadY) &&
                     (w_x >= w_pad_l) && (w_x <= w_pad_l + PadWm1);
   assign w_bottom = r_dir_down && (w_y + HS >= YMax) && !w_pad;
   assign w_wall   = r_dir_right ? (w_x + HS + w_step >= XMax) : (w_x <= HS + w_step);

   // Next-state: FSM, direction resolution (top > paddle > brick), position step
   always_comb begin
      w_state_nxt     = r_state;
      w_x_nxt         = r_x;
      w_y_nxt         = r_y;
      w_dir_right_nxt = r_dir_right;
      w_dir_down_nxt  = r_dir_down;
      w_lives_nxt     = r_lives;
      w_lost_nxt      = 1'b0;
      w_pend_nxt      = 1'b0;
`ifdef BALL_SPEEDUP_EN
      w_step_nxt      = r_step;
      w_bounce_nxt    = r_bounce;
`endif
      unique case (r_state)
         StServe: begin
            if (frame_tick && launch) begin
               w_state_nxt     = StMove;
               w_dir_right_nxt = 1'b1;
               w_dir_down_nxt  = 1'b0;
            end
         end
         StMove: begin
            w_pend_nxt = r_pend | brick_hit;
            if (frame_tick) begin
               w_pend_nxt = 1'b0;
               if (w_bottom) begin
                  w_state_nxt = StLost;
                  w_lost_nxt  = 1'b1;
                  w_lives_nxt = r_lives - 2'd1;
`ifdef BALL_SPEEDUP_EN
                  w_step_nxt   = 4'(STEP);
                  w_bounce_nxt = 3'd0;
`endif
               end else begin
                  w_dir_right_nxt = r_dir_right ^ w_wall;
                  if (w_top) begin
                     w_dir_down_nxt = 1'b1;
                  end else if (w_pad) begin
                     w_dir_down_nxt = 1'b0;
                  end else if (r_pend || brick_hit) begin
                     w_dir_down_nxt = ~r_dir_down;
                  end
                  // Move along the resolved direction, clamped inside the screen
                  if (w_dir_right_nxt) begin
                     w_x_nxt = (w_x + w_step + HS <= XMax) ? 10'(w_x + w_step) : 10'(XMax - HS);
                  end else begin
                     w_x_nxt = (w_x >= HS + w_step) ? 10'(w_x - w_step) : 10'(HS);
                  end
                  if (w_dir_down_nxt) begin
                     w_y_nxt = 9'(w_y + w_step);
                  end else begin
                     w_y_nxt = (w_y >= HS + w_step) ? 9'(w_y - w_step) : 9'(HS);
                  end
`ifdef BALL_SPEEDUP_EN
                  if (w_pad) begin
                     w_bounce_nxt = r_bounce + 3'd1;
                     if ((r_bounce == 3'd7) && (r_step < StepMax)) begin
                        w_step_nxt = r_step + 4'd1;
                     end
                  end
`endif
               end
            end
         end
         StLost: begin
            if (frame_tick) begin
               if (r_lives != 2'd0) begin
                  w_state_nxt = StServe;
                  w_x_nxt     = StartX;
                  w_y_nxt     = StartY;
               end else begin
                  w_state_nxt = StOver;
               end
            end
         end
         StOver: begin
         end
         default: w_state_nxt = StServe;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= StServe;
         r_x         <= StartX;
         r_y         <= StartY;
         r_dir_right <= 1'b1;
         r_dir_down  <= 1'b0;
         r_lives     <= 2'd3;
         r_lost      <= 1'b0;
         r_pend      <= 1'b0;
`ifdef BALL_SPEEDUP_EN
         r_step      <= 4'(STEP);
         r_bounce    <= 3'd0;
`endif
      end else begin
         r_state     <= w_state_nxt;
         r_x         <= w_x_nxt;
         r_y         <= w_y_nxt;
         r_dir_right <= w_dir_right_nxt;
         r_dir_down  <= w_dir_down_nxt;
         r_lives     <= w_lives_nxt;
         r_lost      <= w_lost_nxt;
         r_pend      <= w_pend_nxt;
`ifdef BALL_SPEEDUP_EN
         r_step      <= w_step_nxt;
         r_bounce    <= w_bounce_nxt;
`endif
      end
   end

   assign ball_x    = r_x;
   assign ball_y    = r_y;
   assign lives     = r_lives;
   assign ball_lost = r_lost;
   assign game_over = (r_state == StOver);

endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: scripted frame ticks with expected
// ball position/lives/flags queued per tick and compared after each tick.
`timescale 1ns/1ps
module tb_ball_motion;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       frame_tick = 1'b0;
   logic       launch = 1'b0;
   logic       brick_hit = 1'b0;
   logic [9:0] paddle_x = 10'd0;

   logic [9:0] ball_x;
   logic [8:0] ball_y;
   logic [1:0] lives;
   logic       ball_lost, game_over;

   logic [9:0] e_x;
   logic [8:0] e_y;
   logic [1:0] e_lives;
   logic       e_lost, e_over;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct packed {
      logic [9:0] x;
      logic [8:0] y;
      logic [1:0] lv;
      logic       lost;
      logic       over;
   } obs_t;

   typedef struct packed {
      logic l;
      logic b;
      obs_t e;
   } step_t;

   step_t sb_q[$];

   ball_motion u_dut (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .launch     (launch),
      .brick_hit  (brick_hit),
      .paddle_x   (paddle_x),
      .ball_x     (ball_x),
      .ball_y     (ball_y),
      .lives      (lives),
      .ball_lost  (ball_lost),
      .game_over  (game_over)
   );

   // Second instance served right at the right wall
   ball_motion #(.START_X(637)) u_edge (
      .clk        (clk),
      .reset      (reset),
      .frame_tick (frame_tick),
      .launch     (launch),
      .brick_hit  (brick_hit),
      .paddle_x   (paddle_x),
      .ball_x     (e_x),
      .ball_y     (e_y),
      .lives      (e_lives),
      .ball_lost  (e_lost),
      .game_over  (e_over)
   );

   always #5 clk = ~clk;

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached, got running want finished");
      $fatal(1, "watchdog");
   end

   function automatic obs_t sample();
      obs_t o;
      o.x = ball_x; o.y = ball_y; o.lv = lives; o.lost = ball_lost; o.over = game_over;
      return o;
   endfunction

   function automatic step_t st(input logic l, input logic b, input int x, input int y,
                                input int lv, input logic lost, input logic over);
      step_t s;
      s.l = l; s.b = b;
      s.e.x = 10'(x); s.e.y = 9'(y); s.e.lv = 2'(lv); s.e.lost = lost; s.e.over = over;
      return s;
   endfunction

   // One frame tick; launch/brick_hit are driven in the same cycle as the tick
   task automatic tick(input logic l, input logic b);
      @(negedge clk);
      frame_tick = 1'b1; launch = l; brick_hit = b;
      @(posedge clk);
      #1;
      frame_tick = 1'b0; launch = 1'b0; brick_hit = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      obs_t got, want;
      step_t s;
      repeat (3) @(negedge clk);
      got = sample();
      want = st(0, 0, 320, 400, 3, 0, 0).e;
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL reset_values: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                  got.x, got.y, got.lv, got.lost, got.over, want.x, want.y, want.lv, want.lost, want.over);
      end
      reset = 1'b1;
      // No launch for 5 ticks; a brick pulse in SERVE must be ignored
      for (int i = 0; i < 5; i++) sb_q.push_back(st(0, (i == 2), 320, 400, 3, 0, 0));
      while (sb_q.size() != 0) begin
         s = sb_q.pop_front();
         tick(s.l, s.b);
         got = sample();
         n_checks++;
         if (got !== s.e) begin
            n_fail++;
            $display("FAIL serve_hold: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                     got.x, got.y, got.lv, got.lost, got.over, s.e.x, s.e.y, s.e.lv, s.e.lost, s.e.over);
         end
      end
   endtask

   task automatic test_brick();
      obs_t got;
      step_t s;
      sb_q.push_back(st(1, 0, 320, 400, 3, 0, 0));
      sb_q.push_back(st(0, 0, 321, 399, 3, 0, 0));
      for (int pass = 0; pass < 2; pass++) begin
         while (sb_q.size() != 0) begin
            s = sb_q.pop_front();
            tick(s.l, s.b);
            got = sample();
            n_checks++;
            if (got !== s.e) begin
               n_fail++;
               $display("FAIL brick_flip: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                        got.x, got.y, got.lv, got.lost, got.over, s.e.x, s.e.y, s.e.lv, s.e.lost, s.e.over);
            end
         end
         if (pass == 0) begin
            // Brick pulse between ticks; flip happens at the next tick only
            @(negedge clk); brick_hit = 1'b1;
            @(negedge clk); brick_hit = 1'b0;
            repeat (2) @(negedge clk);
            for (int i = 0; i < 3; i++) sb_q.push_back(st(0, 0, 322 + i, 400 + i, 3, 0, 0));
         end
      end
   endtask

   task automatic test_right_wall();
      do_reset();
      tick(1, 0);
      tick(0, 0);
      n_checks++;
      if (e_x !== 10'd636) begin
         n_fail++;
         $display("FAIL edge_flip: got ball_x=%0d want 636", e_x);
      end
      tick(0, 0);
      n_checks++;
      if (e_x !== 10'd635) begin
         n_fail++;
         $display("FAIL edge_dir: got ball_x=%0d want 635", e_x);
      end
   endtask

   task automatic test_top_wall_brick();
      obs_t got;
      step_t s;
      do_reset();
      tick(1, 0);
      repeat (396) tick(0, 0);
      n_checks++;
      if (ball_x !== 10'd554 || ball_y !== 9'd4) begin
         n_fail++;
         $display("FAIL top_approach: got x=%0d y=%0d want x=554 y=4", ball_x, ball_y);
      end
      sb_q.push_back(st(0, 1, 553, 5, 3, 0, 0));
      sb_q.push_back(st(0, 0, 552, 6, 3, 0, 0));
      sb_q.push_back(st(0, 0, 551, 7, 3, 0, 0));
      while (sb_q.size() != 0) begin
         s = sb_q.pop_front();
         tick(s.l, s.b);
         got = sample();
         n_checks++;
         if (got !== s.e) begin
            n_fail++;
            $display("FAIL top_brick: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                     got.x, got.y, got.lv, got.lost, got.over, s.e.x, s.e.y, s.e.lv, s.e.lost, s.e.over);
         end
      end
   endtask

   task automatic test_paddle();
      obs_t got;
      step_t s;
      do_reset();
      paddle_x = 10'd300;
      sb_q.push_back(st(1, 0, 320, 400, 3, 0, 0));
      sb_q.push_back(st(0, 1, 321, 401, 3, 0, 0));
      for (int n = 1; n <= 36; n++) sb_q.push_back(st(0, 0, 321 + n, 401 + n, 3, 0, 0));
      // Paddle and brick in the same frame: one flip only, to up
      sb_q.push_back(st(0, 1, 358, 436, 3, 0, 0));
      sb_q.push_back(st(0, 0, 359, 435, 3, 0, 0));
      while (sb_q.size() != 0) begin
         s = sb_q.pop_front();
         tick(s.l, s.b);
         got = sample();
         n_checks++;
         if (got !== s.e) begin
            n_fail++;
            $display("FAIL paddle: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                     got.x, got.y, got.lv, got.lost, got.over, s.e.x, s.e.y, s.e.lv, s.e.lost, s.e.over);
         end
      end
   endtask

   task automatic test_lost();
      obs_t got;
      step_t s;
      do_reset();
      paddle_x = 10'd0;
      for (int life = 3; life >= 1; life--) begin
         sb_q.push_back(st(1, 0, 320, 400, life, 0, 0));
         sb_q.push_back(st(0, 1, 321, 401, life, 0, 0));
         for (int n = 1; n <= 75; n++) sb_q.push_back(st(0, 0, 321 + n, 401 + n, life, 0, 0));
         sb_q.push_back(st(0, 0, 396, 476, life - 1, 1, 0));
         while (sb_q.size() != 0) begin
            s = sb_q.pop_front();
            tick(s.l, s.b);
            got = sample();
            n_checks++;
            if (got !== s.e) begin
               n_fail++;
               $display("FAIL lost_fall: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                        got.x, got.y, got.lv, got.lost, got.over, s.e.x, s.e.y, s.e.lv, s.e.lost, s.e.over);
            end
         end
         @(posedge clk);
         #1;
         n_checks++;
         if (ball_lost !== 1'b0) begin
            n_fail++;
            $display("FAIL lost_pulse_width: got ball_lost=%0b want 0", ball_lost);
         end
         if (life > 1) sb_q.push_back(st(0, 0, 320, 400, life - 1, 0, 0));
         else sb_q.push_back(st(0, 0, 396, 476, 0, 0, 1));
      end
      // OVER absorbs launch requests
      for (int i = 0; i < 3; i++) sb_q.push_back(st(1, 0, 396, 476, 0, 0, 1));
      while (sb_q.size() != 0) begin
         s = sb_q.pop_front();
         tick(s.l, s.b);
         got = sample();
         n_checks++;
         if (got !== s.e) begin
            n_fail++;
            $display("FAIL game_over: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                     got.x, got.y, got.lv, got.lost, got.over, s.e.x, s.e.y, s.e.lv, s.e.lost, s.e.over);
         end
      end
   endtask

   task automatic test_back_to_back();
      obs_t got, want;
      step_t s;
      // Asynchronous reset mid-cycle out of OVER, then a normal serve
      @(negedge clk);
      #2 reset = 1'b0;
      #1 got = sample();
      want = st(0, 0, 320, 400, 3, 0, 0).e;
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL async_reset: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                  got.x, got.y, got.lv, got.lost, got.over, want.x, want.y, want.lv, want.lost, want.over);
      end
      @(negedge clk);
      reset = 1'b1;
      sb_q.push_back(st(1, 0, 320, 400, 3, 0, 0));
      sb_q.push_back(st(0, 0, 321, 399, 3, 0, 0));
      sb_q.push_back(st(0, 0, 322, 398, 3, 0, 0));
      while (sb_q.size() != 0) begin
         s = sb_q.pop_front();
         tick(s.l, s.b);
         got = sample();
         n_checks++;
         if (got !== s.e) begin
            n_fail++;
            $display("FAIL reserve: got x=%0d y=%0d lives=%0d lost=%0b over=%0b want x=%0d y=%0d lives=%0d lost=%0b over=%0b",
                     got.x, got.y, got.lv, got.lost, got.over, s.e.x, s.e.y, s.e.lv, s.e.lost, s.e.over);
         end
      end
   endtask

`ifdef BALL_SPEEDUP_EN
   task automatic test_speedup();
      int bounces, prev_y, dy, last_dy, guard;
      do_reset();
      paddle_x = 10'd290;
      tick(1, 0);
      tick(0, 1);
      bounces = 0; last_dy = 1; guard = 0; prev_y = int'(ball_y);
      // Rally between the paddle (kept under the ball) and brick flips
      while (bounces < 8 && guard < 2000) begin
         paddle_x = ball_x - 10'd32;
         tick(0, (last_dy < 0));
         dy = int'(ball_y) - prev_y;
         prev_y = int'(ball_y);
         if (last_dy > 0 && dy < 0) bounces++;
         last_dy = dy;
         guard++;
      end
      n_checks++;
      if (bounces != 8) begin
         n_fail++;
         $display("FAIL speedup_bounces: got %0d bounces want 8", bounces);
      end
      tick(0, 1);
      dy = int'(ball_y) - prev_y;
      n_checks++;
      if (dy != 2) begin
         n_fail++;
         $display("FAIL speedup_step: got dy=%0d want 2", dy);
      end
      paddle_x = (ball_x < 10'd320) ? 10'd600 : 10'd0;
      guard = 0;
      while (ball_lost !== 1'b1 && guard < 500) begin
         tick(0, 0);
         guard++;
      end
      n_checks++;
      if (ball_lost !== 1'b1) begin
         n_fail++;
         $display("FAIL speedup_lost: got ball_lost=%0b want 1", ball_lost);
      end
      tick(0, 0);
      tick(1, 0);
      tick(0, 0);
      n_checks++;
      if (ball_y !== 9'd399) begin
         n_fail++;
         $display("FAIL step_restored: got y=%0d want 399", ball_y);
      end
   endtask
`endif

   initial begin
      test_reset();
      test_brick();
      test_right_wall();
      test_top_wall_brick();
      test_paddle();
      test_lost();
      test_back_to_back();
`ifdef BALL_SPEEDUP_EN
      test_speedup();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
